// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment driver for a common-anode bank: shadow-registered content,
// prescaled digit scan with one forced all-off cycle at each digit switch.
module seg_scan_display #(
    parameter int DIGITS  = 2,
    parameter int CLK_DIV = 100000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     anode,
    output logic [6:0]            cathode,
    output logic                  dp_n
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] val_q, val_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic [DIGITS-1:0]   dp_q, dp_d;
    logic [DIGITS-1:0]   anode_q, anode_d;
    logic [6:0]          cathode_q, cathode_d;
    logic                dp_n_q, dp_n_d;

    logic                tc;
    logic [3:0]          cur_nib;
    logic                cur_blank;
    logic                cur_dp;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    always_comb begin
        tc    = (pre_q == PRE_LAST);
        pre_d = tc ? '0 : pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (tc) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        val_d   = load ? value : val_q;
        blank_d = load ? blank : blank_q;
        dp_d    = load ? dp    : dp_q;
    end

    // Explicit compare-and-select keeps the mux in range for non-power-of-two DIGITS.
    always_comb begin
        cur_nib   = '0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = val_q[4*i +: 4];
                cur_blank = blank_q[i];
                cur_dp    = dp_q[i];
            end
        end
    end

    always_comb begin
        anode_d   = '1;
        cathode_d = 7'b1111111;
        dp_n_d    = 1'b1;
        if (!(tc || cur_blank)) begin
            for (int i = 0; i < DIGITS; i++) begin
                anode_d[i] = (idx_q != IDX_W'(i));
            end
            cathode_d = hex_to_seg(cur_nib);
            dp_n_d    = ~cur_dp;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q     <= '0;
            idx_q     <= '0;
            val_q     <= '0;
            blank_q   <= '0;
            dp_q      <= '0;
            anode_q   <= '1;
            cathode_q <= 7'b1111111;
            dp_n_q    <= 1'b1;
        end else begin
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            val_q     <= val_d;
            blank_q   <= blank_d;
            dp_q      <= dp_d;
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
            dp_n_q    <= dp_n_d;
        end
    end

    assign anode   = anode_q;
    assign cathode = cathode_q;
    assign dp_n    = dp_n_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: three parameterisations share clock and reset;
// stimulus queues expected outputs per cycle, a negedge monitor pops and compares.
module tb_seg_scan_display;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic        load_a = 1'b0, load_b = 1'b0, load_c = 1'b0;
    logic [7:0]  val_a = '0;
    logic [15:0] val_b = '0;
    logic [11:0] val_c = '0;
    logic [1:0]  blank_a = '0, dp_a = '0;
    logic [3:0]  blank_b = '0, dp_b = '0;
    logic [2:0]  blank_c = '0, dp_c = '0;
    logic [1:0]  an_a;
    logic [3:0]  an_b;
    logic [2:0]  an_c;
    logic [6:0]  ca_a, ca_b, ca_c;
    logic        dpn_a, dpn_b, dpn_c;

    seg_scan_display #(.DIGITS(2), .CLK_DIV(4)) u_a (
        .clock(clock), .reset(reset), .load(load_a), .value(val_a), .blank(blank_a),
        .dp(dp_a), .anode(an_a), .cathode(ca_a), .dp_n(dpn_a));
    seg_scan_display #(.DIGITS(4), .CLK_DIV(3)) u_b (
        .clock(clock), .reset(reset), .load(load_b), .value(val_b), .blank(blank_b),
        .dp(dp_b), .anode(an_b), .cathode(ca_b), .dp_n(dpn_b));
    seg_scan_display #(.DIGITS(3), .CLK_DIV(5)) u_c (
        .clock(clock), .reset(reset), .load(load_c), .value(val_c), .blank(blank_c),
        .dp(dp_c), .anode(an_c), .cathode(ca_c), .dp_n(dpn_c));

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         dut;
        logic [3:0] an;
        logic [6:0] ca;
        logic       dpn;
        string      tag;
    } exp_t;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    string cur_tag  = "reset";

    logic [6:0] dec [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    logic [6:0] exp_cath [4];
    logic       exp_dpn  [4];
    logic       exp_blank[4];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic push_exp(input int c, input int dut, input logic [3:0] an,
                            input logic [6:0] ca, input logic dpn);
        exp_t e;
        e.cyc = c; e.dut = dut; e.an = an; e.ca = ca; e.dpn = dpn; e.tag = cur_tag;
        sb.push_back(e);
    endtask

    task automatic push_dark(input int c, input int dut);
        push_exp(c, dut, 4'hF, 7'b1111111, 1'b1);
    endtask

    task automatic push_lit(input int c, input int dut, input int digit);
        logic [3:0] an;
        an = 4'hF;
        an[digit] = 1'b0;
        push_exp(c, dut, an, exp_cath[digit], exp_dpn[digit]);
    endtask

    // Expands the documented scan pattern: CLK_DIV-1 lit cycles then one dark cycle per digit.
    task automatic push_scan(input int dut, input int start, input int nd, input int cdiv,
                             input int first_digit, input int first_pre, input int ncyc);
        int d;
        int p;
        d = first_digit;
        p = first_pre;
        for (int j = 0; j < ncyc; j++) begin
            if (p == cdiv - 1 || exp_blank[d]) push_dark(start + j, dut);
            else push_lit(start + j, dut, d);
            p++;
            if (p == cdiv) begin
                p = 0;
                d = (d + 1) % nd;
            end
        end
    endtask

    task automatic set_exp_all(input logic [6:0] ca, input logic dpn);
        for (int i = 0; i < 4; i++) begin
            exp_cath[i]  = ca;
            exp_dpn[i]   = dpn;
            exp_blank[i] = 1'b0;
        end
    endtask

    task automatic do_reset(output int r);
        cur_tag = "reset";
        reset = 1'b1;
        tick();
        push_dark(cyc, 0);
        push_dark(cyc, 1);
        push_dark(cyc, 2);
        reset = 1'b0;
        r = cyc;
    endtask

    initial begin : monitor
        exp_t       e;
        logic [3:0] act_an;
        logic [6:0] act_ca;
        logic       act_dpn;
        forever begin
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (e.cyc < cyc) begin
                    n_fail++;
                    $display("FAIL %s dut%0d cyc %0d: expectation missed (now cyc %0d)",
                             e.tag, e.dut, e.cyc, cyc);
                end else begin
                    case (e.dut)
                        0:       begin act_an = {2'b11, an_a}; act_ca = ca_a; act_dpn = dpn_a; end
                        1:       begin act_an = an_b;          act_ca = ca_b; act_dpn = dpn_b; end
                        default: begin act_an = {1'b1, an_c};  act_ca = ca_c; act_dpn = dpn_c; end
                    endcase
                    if (act_an !== e.an || act_ca !== e.ca || act_dpn !== e.dpn) begin
                        n_fail++;
                        $display("FAIL %s dut%0d cyc %0d: got anode=%b cathode=%b dp_n=%b, want anode=%b cathode=%b dp_n=%b",
                                 e.tag, e.dut, e.cyc, act_an, act_ca, act_dpn, e.an, e.ca, e.dpn);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    logic [1:0]  an_tab_a [8]  = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b11};
    logic [2:0]  an_tab_c [15] = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b111,
                                   3'b101, 3'b101, 3'b101, 3'b101, 3'b111,
                                   3'b011, 3'b011, 3'b011, 3'b011, 3'b111};
    logic [15:0] sweep [4]     = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};

    initial begin : stimulus
        int r;
        int r2;
        logic [3:0] an;

        // Idle scan on DIGITS=2, CLK_DIV=4, from the fixed anode sequence.
        do_reset(r);
        cur_tag = "idle_scan";
        for (int k = 0; k < 16; k++) begin
            an = {2'b11, an_tab_a[k % 8]};
            push_exp(r + 1 + k, 0, an, (an == 4'hF) ? 7'b1111111 : 7'b0000001, 1'b1);
        end

        // Mid-slot load of 8'h21 / dp 10: old content on the load edge, new from the next.
        tick_to(r + 16);
        load_a = 1'b1; val_a = 8'h21; dp_a = 2'b10; blank_a = 2'b00;
        cur_tag = "load_latency";
        set_exp_all(7'b0000001, 1'b1);
        push_lit(r + 17, 0, 0);
        tick();
        load_a = 1'b0;
        cur_tag = "load_21";
        exp_cath[0] = dec[1]; exp_dpn[0] = 1'b1;
        exp_cath[1] = dec[2]; exp_dpn[1] = 1'b0;
        push_lit(r + 18, 0, 0);
        push_lit(r + 19, 0, 0);
        push_dark(r + 20, 0);
        push_scan(0, r + 21, 2, 4, 1, 0, 15);

        // Blanking digit 0, digit 1 shows F; load lands on a tc edge.
        tick_to(r + 35);
        load_a = 1'b1; val_a = 8'hF3; blank_a = 2'b01; dp_a = 2'b00;
        push_dark(r + 36, 0);
        tick();
        load_a = 1'b0;
        cur_tag = "blanking";
        exp_blank[0] = 1'b1;
        exp_cath[1] = dec[15]; exp_dpn[1] = 1'b1;
        push_scan(0, r + 37, 2, 4, 1, 0, 24);

        // Load 8'h55 on the edge with pre=3, idx=0: digit 1's next slot shows 5.
        tick_to(r + 59);
        load_a = 1'b1; val_a = 8'h55; blank_a = 2'b00; dp_a = 2'b00;
        tick();
        load_a = 1'b0;
        cur_tag = "load_at_tc";
        set_exp_all(dec[5], 1'b1);
        push_scan(0, r + 61, 2, 4, 1, 0, 2);

        // Reset with idx=1, pre=2, then digit 0 shows "0" again.
        tick_to(r + 62);
        do_reset(r2);
        cur_tag = "after_mid_reset";
        set_exp_all(7'b0000001, 1'b1);
        push_scan(0, r2 + 1, 2, 4, 0, 0, 8);
        tick_to(r2 + 8);

        // Full decode sweep on DIGITS=4, CLK_DIV=3.
        do_reset(r);
        cur_tag = "sweep_idle";
        set_exp_all(7'b0000001, 1'b1);
        push_scan(1, r + 1, 4, 3, 0, 0, 12);
        for (int v = 0; v < 4; v++) begin
            tick_to(r + 11 + 12 * v);
            load_b = 1'b1; val_b = sweep[v]; blank_b = '0; dp_b = '0;
            tick();
            load_b = 1'b0;
            cur_tag = $sformatf("sweep_%04h", sweep[v]);
            for (int i = 0; i < 4; i++) exp_cath[i] = dec[sweep[v][4*i +: 4]];
            push_scan(1, r + 13 + 12 * v, 4, 3, 0, 0, 12);
        end
        tick_to(r + 60);

        // Non-power-of-two wrap on DIGITS=3, CLK_DIV=5 over two periods.
        do_reset(r);
        cur_tag = "wrap_3x5";
        for (int k = 0; k < 30; k++) begin
            an = {1'b1, an_tab_c[k % 15]};
            push_exp(r + 1 + k, 2, an, (an == 4'hF) ? 7'b1111111 : 7'b0000001, 1'b1);
        end
        tick_to(r + 31);
        @(negedge clock);
        #1;

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s dut%0d cyc %0d: expectation never checked", e.tag, e.dut, e.cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised multiplexed seven-segment display driver for the board's common-anode display bank. It generalises the fixed two-digit write/read block indicator to `DIGITS` digits, each showing any hex nibble, with per-digit blanking and decimal points. It time-multiplexes the digits with a programmable refresh prescaler and forces one all-off cycle at every digit switch to suppress ghosting. Controller logic feeds it a packed value word and a load strobe; its outputs go straight to the anode/cathode package pins.

## Interface
- `DIGITS`, default 2: number of digits scanned (≥1); digit 0 is the rightmost.
- `CLK_DIV`, default 100000: clock cycles per digit slot (≥2).
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `load` in 1: when high, capture `value`, `blank` and `dp` into the shadow registers.
- `value` in 4*DIGITS: nibble i (`value[4i+3:4i]`) is shown on digit i.
- `blank` in DIGITS: 1 = digit i is dark for its whole slot.
- `dp` in DIGITS: 1 = decimal point lit on digit i.
- `anode` out DIGITS: active-low digit enables, one-hot-low or all-high.
- `cathode` out 7: active-low segments, `[6]`=a … `[0]`=g.
- `dp_n` out 1: active-low decimal point.

## Operation
- **Shadow registers:** `val_q`, `blank_q` and `dp_q` load on any edge with `load`=1. Otherwise they hold. Display content changes only through `load`.
- **Prescaler:** `pre` counts 0..CLK_DIV-1 and wraps to 0. Its width is ceil(log2(CLK_DIV)). Terminal count `tc` = (`pre`==CLK_DIV-1).
- **Digit index:** `idx` increments on edges where `tc`=1 and wraps from DIGITS-1 to 0. Its width is max(1, ceil(log2(DIGITS))).
- **Output register:** all outputs are registered. Each edge computes them from the current `pre`, `idx` and shadow registers.
  - If `tc`=1 or `blank_q[idx]`=1: `anode` is all 1s, `cathode`=7'b1111111 and `dp_n`=1.
  - Otherwise: `anode` has bit `idx` at 0 and all others at 1; `cathode`=hex(`val_q[idx]`); `dp_n`=~`dp_q[idx]`.
- **Hex decode (abcdefg, active low):**
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- **Scan pattern:** each digit is driven for CLK_DIV-1 consecutive cycles, followed by 1 all-off cycle. The full period is DIGITS*CLK_DIV cycles.
- **Single digit:** with DIGITS=1, `idx` stays 0 and the dark cycle still occurs every CLK_DIV cycles.

## Timing
- **Reset values** (on any edge with `reset`=1, including mid-scan):
  - `pre`=0, `idx`=0, and all shadow registers cleared.
  - `anode` all 1s, `cathode`=7'b1111111, `dp_n`=1.
  - Reset overrides a simultaneous `load`.
- **First edge after reset release (t0):** outputs reflect `pre`=0 and `idx`=0, so digit 0 shows "0" (0000001).
- **Load latency:** `load` sampled at edge L gives new content on the outputs from edge L+1, provided the digit is in its lit window at that point.
- **Load coinciding with `tc`:** the shadow registers and `idx` update on the same edge. The next digit shows the new value.
- **Asynchronous inputs:** `value`, `blank` and `dp` are ignored when `load`=0. There is no handshake; `load` may be held high continuously, which tracks the inputs with 1-cycle latency.
- **Counter wrap:** `pre` and `idx` never exceed CLK_DIV-1 and DIGITS-1, including for non-power-of-two parameters.

## Test plan
- **Reset and idle scan:** DIGITS=2, CLK_DIV=4, no load, then release reset.
  - From t0, `anode` repeats 10,10,10,11,01,01,01,11.
  - `cathode`=0000001 while a digit is lit, and 1111111 while `anode`=11.
- **Load:** `load`=1 for one cycle with `value`=8'h21, `dp`=2'b10.
  - Digit 0 slots show `cathode`=1001111 with `dp_n`=1.
  - Digit 1 slots show `cathode`=0010010 with `dp_n`=0.
- **Full decode sweep:** DIGITS=4, CLK_DIV=3; load 16'h0123, then 16'h4567, 16'h89AB and 16'hCDEF.
  - Every nibble's `cathode` must match the decode list.
  - Each digit is lit for 2 cycles and dark for 1.
- **Blanking:** `blank`=2'b01 loaded with `value`=8'hF3.
  - `anode` stays 11 throughout digit 0's slot.
  - Digit 1 shows 0111000.
- **Simultaneous and mid-operation events:**
  - Assert `load` (value 8'h55) on the edge where `pre`=3 and `idx`=0: digit 1's next slot shows 0100100.
  - Assert `reset` with `idx`=1 and `pre`=2: the next edge gives `anode`=11 and `cathode`=1111111, and digit 0 shows "0" after release.
- **Non-power-of-two wrap:** DIGITS=3, CLK_DIV=5, run 2 full periods.
  - `anode` sequence is 110×4, 111, 101×4, 111, 011×4, 111, repeating.
  - `idx` never reads 3.
